seq_cla_adder: RTL and testbench

SEQ_CLA_ADDER -- requirements
Module: seq_cla_adder

---
 rtl/seq_cla_adder.sv | 136 +++++++++++++
 tb/tb_seq_cla_adder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_cla_adder.sv
// seq_cla_adder: 16-bit adder computed one nibble per clock through a
// 4-bit carry-lookahead slice. Group generate/propagate terms are folded
// across the nibbles, so the block also reports the 16-bit group G/P.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   a, b   - 16-bit operands, sampled only when start is accepted in IDLE
//   c      - carry-in, sampled only when start is accepted in IDLE
//   start  - request a new addition; ignored while busy
//   busy   - high in RUN and DONE
//   done   - one-cycle pulse; s/co/g/p/ovf are valid from this cycle
//   s      - sum (modulo 2^16)
//   co     - carry out of bit 15
//   g, p   - 16-bit group generate / propagate
//   ovf    - two's-complement overflow (carry into bit 15 ^ carry out)
module seq_cla_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] s,
    output logic        co,
    output logic        g,
    output logic        p,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx;        // nibble being processed in RUN
    logic [15:0] a_r, b_r;
    logic        carry;      // running carry into the current nibble
    logic        g_acc, p_acc;
    logic [11:0] sum_r;      // low three nibbles; kept off s until completion

    // Current nibble slice
    logic [3:0] na, nb, bg, bp, hs, cin_v, nsum;
    logic       c1, c2, c3, c4, g_nib, p_nib;

    assign na = a_r[{idx, 2'b00} +: 4];
    assign nb = b_r[{idx, 2'b00} +: 4];
    assign bg = na & nb;
    assign bp = na | nb;
    assign hs = na ^ nb;

    // Flat two-level lookahead: every carry is a sum of products of the
    // bit g/p terms and the nibble carry-in, with no ripple between bits.
    assign c1 = bg[0] | (bp[0] & carry);
    assign c2 = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & carry);
    assign c3 = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
              | (bp[2] & bp[1] & bp[0] & carry);
    assign g_nib = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                 | (bp[3] & bp[2] & bp[1] & bg[0]);
    assign p_nib = &bp;
    assign c4    = g_nib | (p_nib & carry);

    assign cin_v = {c3, c2, c1, carry};
    assign nsum  = hs ^ cin_v;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            g_acc <= 1'b0;
            p_acc <= 1'b0;
            sum_r <= '0;
            s     <= '0;
            co    <= 1'b0;
            g     <= 1'b0;
            p     <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= c;
                        idx   <= 2'd0;
                        g_acc <= 1'b0;
                        p_acc <= 1'b1;
                    end
                end
                RUN: begin
                    carry <= c4;
                    g_acc <= g_nib | (p_nib & g_acc);
                    p_acc <= p_nib & p_acc;
                    idx   <= idx + 2'd1;
                    case (idx)
                        2'd0: sum_r[3:0]  <= nsum;
                        2'd1: sum_r[7:4]  <= nsum;
                        2'd2: sum_r[11:8] <= nsum;
                        default: begin
                            // Last nibble: publish the whole result at once
                            s   <= {nsum, sum_r};
                            co  <= c4;
                            g   <= g_nib | (p_nib & g_acc);
                            p   <= p_nib & p_acc;
                            ovf <= c3 ^ c4;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_cla_adder.sv
module tb_seq_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        c, start;
    logic        busy, done, co, g, p, ovf;
    logic [15:0] s;

    int checks = 0;
    int failures = 0;

    seq_cla_adder dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .start(start),
        .busy(busy), .done(done), .s(s), .co(co), .g(g), .p(p), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        c;
        logic [15:0] s;
        logic        co, g, p, ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE and wait (bounded) for done.
    // Operands are scrambled right after acceptance to prove they are latched.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          output int lat, output logic [19:0] res,
                          output bit stable, output bit busy_ok);
        logic [15:0] s0;
        s0 = s;
        @(negedge clk);
        a = ta; b = tb_; c = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
        lat = 1; stable = 1; busy_ok = 1;
        while (!done && lat < 20) begin
            if (s !== s0) stable = 0;
            if (busy !== 1'b1) busy_ok = 0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 0;
        res = {co, g, p, ovf, s};
    endtask

    initial begin
        int lat;
        logic [19:0] res;
        bit stable, busy_ok, seen;
        int dcount, last, gaps_ok;
        logic [16:0] ref_sum;
        logic [15:0] ra, rb;
        logic rc, ref_ovf, ref_g, ref_p;

        //            a         b         c     s         co    g     p     ovf
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; a = '0; b = '0; c = 1'b0; start = 1'b0;
        #1;
        chk("reset_outputs", {busy, done, co, g, p, ovf, s}, '0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", {busy, done}, '0);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, lat, res, stable, busy_ok);
            chk($sformatf("vec%0d_latency", i), lat, 5);
            chk($sformatf("vec%0d_result", i), res,
                {vecs[i].co, vecs[i].g, vecs[i].p, vecs[i].ovf, vecs[i].s});
            chk($sformatf("vec%0d_s_hidden", i), stable, 1);
            chk($sformatf("vec%0d_busy", i), busy_ok, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), {busy, done}, '0);
            chk($sformatf("vec%0d_hold", i), s, vecs[i].s);
        end

        // Start pulsed while busy must be ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; c = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; c = 1'b1;   // start stays high during RUN
        lat = 1;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("busy_start_latency", lat, 5);
        chk("busy_start_s", {co, s}, {1'b0, 16'h5555});
        start = 1'b0;
        @(negedge clk);
        chk("busy_start_back_idle", busy, 0);

        // Start held continuously: one done every 6 cycles, each s=2
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; c = 1'b0; start = 1'b1;
        dcount = 0; last = -1; gaps_ok = 1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (s !== 16'h0002 || co !== 1'b0) gaps_ok = 0;
                if (last >= 0 && cyc - last != 6) gaps_ok = 0;
                if (last < 0 && cyc != 5) gaps_ok = 0;
                last = cyc;
                dcount++;
            end
        end
        start = 1'b0;
        chk("cont_done_count", dcount, 6);
        chk("cont_period_and_sum", gaps_ok, 1);
        while (busy) @(negedge clk);

        // Reset between the 2nd and 3rd RUN edge
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; c = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;   // RUN, nibble 0 pending
        @(negedge clk);                 // after RUN edge 1
        @(negedge clk);                 // after RUN edge 2
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {busy, done, co, g, p, ovf, s}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("midreset_no_done", seen, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, lat, res, stable, busy_ok);
        chk("after_reset_latency", lat, 5);
        chk("after_reset_result", {res[19], res[15:0]}, {1'b0, 16'h0100});

        // Random regression
        for (int n = 0; n < 10000; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            ref_ovf = (ra[15] == rb[15]) && (ref_sum[15] != ra[15]);
            ref_g   = 1'(({1'b0, ra} + {1'b0, rb}) >> 16);
            ref_p   = &(ra | rb);
            run_op(ra, rb, rc, lat, res, stable, busy_ok);
            chk($sformatf("rand%0d a=%h b=%h c=%0d", n, ra, rb, rc),
                {lat[7:0], res},
                {8'd5, ref_sum[16], ref_g, ref_p, ref_ovf, ref_sum[15:0]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
